vcve2_agu_mc: RTL

Multi-channel vector address generator for the vcve2 VRF memory port. It generalises the fixed rs1/rs2/rd counter AGU to NumCh independent channels. New capabilities: configurable VLEN and bus width, register grouping (LMUL 1/2/4/8), per-channel start offsets (slides), wrap-around mode (rotate/gather), per-channel completion tracking and misaligned-group detection. The block sits between the vector decoder/sequencer and the VRF memory request path. It produces one word address per request from the selected channel.

---
 rtl/vcve2_agu_mc.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vcve2_agu_mc.sv
// Multi-channel VRF address generator: per-channel register groups,
// start offsets, wrap-around sequencing and misaligned-group detection.
module vcve2_agu_mc #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned NumCh = 3,
  parameter int unsigned VregBytes = 16,
  parameter int unsigned WordBytes = 4,
  parameter logic [AddrWidth-1:0] VrfBaseAddr = 32'h0000_1000,
  localparam int unsigned SelW = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [NumCh*5-1:0]   vreg_idx_i,
  input  logic [1:0]           lmul_i,
  input  logic [NumCh-1:0]     offset_en_i,
  input  logic [NumCh-1:0]     wrap_en_i,
  input  logic [AddrWidth-1:0] offset_i,
  input  logic [SelW-1:0]      sel_i,
  input  logic                 req_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 addr_valid_o,
  output logic                 last_o,
  output logic [NumCh-1:0]     ch_done_o,
  output logic                 illegal_o
);

  localparam int unsigned W  = VregBytes / WordBytes;
  localparam int unsigned PW = $clog2(8 * W);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OB = $clog2(WordBytes);
  localparam int unsigned RB = $clog2(VregBytes);

  logic [AddrWidth-1:0] base_q [NumCh];
  logic [PW-1:0]        ptr_q  [NumCh];
  logic [CW-1:0]        cnt_q  [NumCh];
  logic [NumCh-1:0]     wrap_q;
  logic [NumCh-1:0]     done_q;
  logic                 illegal_q;
  logic [CW-1:0]        gw_q;

  logic [CW-1:0]        gw_ld;
  logic [AddrWidth-1:0] slot;
  logic                 slot_big;
  logic [4:0]           gmask;
  logic                 bad;
  logic [AddrWidth-1:0] base_ld [NumCh];
  logic [PW-1:0]        ptr_ld  [NumCh];
  logic [CW-1:0]        cnt_ld  [NumCh];
  logic [NumCh-1:0]     skip_ld;

  assign gw_ld    = CW'(W) << lmul_i;
  assign slot     = offset_i >> OB;
  assign slot_big = slot >= AddrWidth'(gw_ld);
  assign gmask    = ~(5'h1f << lmul_i);

  // Load-time values for every channel, committed together on load_i.
  always_comb begin
    bad     = 1'b0;
    base_ld = '{default: '0};
    ptr_ld  = '{default: '0};
    cnt_ld  = '{default: '0};
    skip_ld = '0;
    for (int k = 0; k < NumCh; k++) begin
      bad = bad | (|(vreg_idx_i[5*k +: 5] & gmask));
      base_ld[k] = VrfBaseAddr
                 + (AddrWidth'(vreg_idx_i[5*k +: 5]) << RB);
      ptr_ld[k]  = offset_en_i[k] ? slot[PW-1:0] : '0;
      skip_ld[k] = offset_en_i[k] & slot_big;
      if (skip_ld[k])
        cnt_ld[k] = '0;
      else if (wrap_en_i[k])
        cnt_ld[k] = gw_ld;
      else
        cnt_ld[k] = gw_ld - CW'(ptr_ld[k]);
    end
  end

  logic            sel_ok;
  logic [SelW-1:0] si;
  logic            valid;
  logic [CW-1:0]   ptr_nx;

  assign sel_ok = 32'(sel_i) < NumCh;
  assign si     = sel_ok ? sel_i : '0;
  assign valid  = req_i & sel_ok & ~done_q[si] & ~load_i & ~rst_i;
  assign ptr_nx = {1'b0, ptr_q[si]} + CW'(1);

  assign addr_valid_o = valid;
  assign addr_o = valid ? base_q[si] + (AddrWidth'(ptr_q[si]) << OB)
                        : '0;
  assign last_o    = valid & (cnt_q[si] == CW'(1));
  assign ch_done_o = done_q;
  assign illegal_o = illegal_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumCh; k++) begin
        base_q[k] <= '0;
        ptr_q[k]  <= '0;
        cnt_q[k]  <= '0;
      end
      wrap_q    <= '0;
      done_q    <= '1;
      illegal_q <= 1'b0;
      gw_q      <= '0;
    end else if (load_i) begin
      for (int k = 0; k < NumCh; k++) begin
        base_q[k] <= base_ld[k];
        ptr_q[k]  <= ptr_ld[k];
        cnt_q[k]  <= cnt_ld[k];
        wrap_q[k] <= wrap_en_i[k];
        done_q[k] <= bad | skip_ld[k];
      end
      illegal_q <= bad;
      gw_q      <= gw_ld;
    end else if (valid) begin
      cnt_q[si] <= cnt_q[si] - CW'(1);
      if (cnt_q[si] == CW'(1))
        done_q[si] <= 1'b1;
      // Non-wrap channels hold ptr at the group end; they are done there.
      if (ptr_nx != gw_q)
        ptr_q[si] <= ptr_nx[PW-1:0];
      else if (wrap_q[si])
        ptr_q[si] <= '0;
    end
  end

endmodule
